// File: rtl/lcd_rx_monitor.sv
`default_nettype none
// ============================================================================
// lcd_rx_monitor : parallel RGB LCD receiver; rebuilds pixel stream/coordinates,
//                  checks line/frame geometry, checksums frames, reports lock.
// Revision: 1.0
// ============================================================================
module lcd_rx_monitor #(
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk_in,
    input  logic        sys_rst,
    input  logic [23:0] rgb_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        line_done,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [11:0] h_total,
    output logic        err_h,
    output logic        err_v,
    output logic        locked
);

    localparam logic [1:0]  ST_SEARCH = 2'd0;
    localparam logic [1:0]  ST_SYNCED = 2'd1;
    localparam logic [1:0]  ST_LOCKED = 2'd2;

    localparam logic [10:0] C_H_EXP    = 11'(H_ACTIVE);
    localparam logic [10:0] C_V_EXP    = 11'(V_ACTIVE);
    localparam logic [3:0]  C_LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic        C_SYNC_INV = (SYNC_ACTIVE_LOW != 0);
    localparam logic [10:0] C_CNT_MAX  = 11'h7FF;
    localparam logic [11:0] C_H_MAX    = 12'hFFF;

    // Input pipeline; sync levels stored as "asserted" = 1
    logic [23:0] rgb_s1_q;
    logic        hs_s1_q, vs_s1_q, de_s1_q;
    logic        hs_s2_q, vs_s2_q, de_s2_q;

    logic [1:0]  state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [31:0] sum_q, sum_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [3:0]  clean_q, clean_d;
    logic        frame_bad_q, frame_bad_d;

    logic        pix_valid_q, pix_valid_d;
    logic [23:0] pix_data_q, pix_data_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [10:0] pix_y_q, pix_y_d;
    logic        line_done_q, line_done_d;
    logic        frame_done_q, frame_done_d;
    logic [31:0] frame_sum_q, frame_sum_d;
    logic [11:0] h_total_q, h_total_d;
    logic        err_h_q, err_h_d;
    logic        err_v_q, err_v_d;

    logic        w_hs_norm, w_vs_norm;
    logic        w_acc, w_acc_prev, w_trail, w_vs_lead, w_hs_lead;
    logic        w_checking, w_clean;
    logic [10:0] w_x_inc, w_lines;
    logic [3:0]  w_clean_inc;

    assign w_hs_norm = C_SYNC_INV ? ~hsync_in : hsync_in;
    assign w_vs_norm = C_SYNC_INV ? ~vsync_in : vsync_in;

    // de during vsync is not part of the picture, so edges are taken on the
    // qualified enable rather than raw de
    assign w_acc      = de_s1_q & ~vs_s1_q;
    assign w_acc_prev = de_s2_q & ~vs_s2_q;
    assign w_trail    = w_acc_prev & ~w_acc;
    assign w_vs_lead  = vs_s1_q & ~vs_s2_q;
    assign w_hs_lead  = hs_s1_q & ~hs_s2_q;

    assign w_x_inc     = (x_q == C_CNT_MAX) ? x_q : x_q + 11'd1;
    assign w_lines     = (w_trail && (y_q != C_CNT_MAX)) ? y_q + 11'd1 : y_q;
    assign w_clean_inc = (clean_q == 4'hF) ? clean_q : clean_q + 4'd1;

    assign w_checking = (state_q != ST_SEARCH);
    assign err_h_d    = w_trail & w_checking & (x_q != C_H_EXP);
    assign err_v_d    = w_vs_lead & w_checking & (w_lines != C_V_EXP);
    assign w_clean    = ~(frame_bad_q | err_h_d | err_v_d);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        sum_d        = sum_q;
        h_cnt_d      = h_cnt_q;
        clean_d      = clean_q;
        frame_bad_d  = frame_bad_q;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_sum_d  = frame_sum_q;
        h_total_d    = h_total_q;

        if (w_hs_lead) begin
            h_total_d = h_cnt_q;
            h_cnt_d   = 12'd1;
        end else if (h_cnt_q != C_H_MAX) begin
            h_cnt_d = h_cnt_q + 12'd1;
        end

        if (w_acc) begin
            pix_valid_d = 1'b1;
            pix_data_d  = rgb_s1_q;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            x_d         = w_x_inc;
            sum_d       = sum_q + {8'd0, rgb_s1_q};
        end

        if (w_trail) begin
            line_done_d = 1'b1;
            x_d         = 11'd0;
            y_d         = w_lines;
        end

        if (err_h_d) begin
            frame_bad_d = 1'b1;
        end

        // Lock is dropped one cycle after an error pulse is visible
        if ((state_q == ST_LOCKED) && (err_h_q || err_v_q)) begin
            state_d = ST_SYNCED;
            clean_d = 4'd0;
        end

        // The line closed in this cycle is already folded into w_lines
        if (w_vs_lead) begin
            x_d         = 11'd0;
            y_d         = 11'd0;
            sum_d       = 32'd0;
            frame_bad_d = 1'b0;
            if (state_q == ST_SEARCH) begin
                state_d = ST_SYNCED;
            end else begin
                frame_done_d = 1'b1;
                frame_sum_d  = sum_q;
                if (w_clean) begin
                    clean_d = w_clean_inc;
                    if (w_clean_inc >= C_LOCK_N) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    clean_d = 4'd0;
                    state_d = ST_SYNCED;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            rgb_s1_q     <= 24'd0;
            hs_s1_q      <= 1'b0;
            vs_s1_q      <= 1'b0;
            de_s1_q      <= 1'b0;
            hs_s2_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            de_s2_q      <= 1'b0;
            state_q      <= ST_SEARCH;
            x_q          <= 11'd0;
            y_q          <= 11'd0;
            sum_q        <= 32'd0;
            h_cnt_q      <= 12'd0;
            clean_q      <= 4'd0;
            frame_bad_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= 24'd0;
            pix_x_q      <= 11'd0;
            pix_y_q      <= 11'd0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_sum_q  <= 32'd0;
            h_total_q    <= 12'd0;
            err_h_q      <= 1'b0;
            err_v_q      <= 1'b0;
        end else begin
            rgb_s1_q     <= rgb_in;
            hs_s1_q      <= w_hs_norm;
            vs_s1_q      <= w_vs_norm;
            de_s1_q      <= de_in;
            hs_s2_q      <= hs_s1_q;
            vs_s2_q      <= vs_s1_q;
            de_s2_q      <= de_s1_q;
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sum_q        <= sum_d;
            h_cnt_q      <= h_cnt_d;
            clean_q      <= clean_d;
            frame_bad_q  <= frame_bad_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            frame_sum_q  <= frame_sum_d;
            h_total_q    <= h_total_d;
            err_h_q      <= err_h_d;
            err_v_q      <= err_v_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign h_total    = h_total_q;
    assign err_h      = err_h_q;
    assign err_v      = err_v_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_lcd_rx_monitor.sv
`default_nettype none
// ============================================================================
// tb_lcd_rx_monitor : randomized frames checked cycle by cycle against a
//                     behavioural receiver model, plus fixed-value anchors.
// Revision: 1.0
// ============================================================================
module tb_lcd_rx_monitor;

    localparam int C_H = 8;
    localparam int C_V = 4;
    localparam int C_LOCK = 2;

    logic        clk_in, sys_rst;
    logic [23:0] rgb_in;
    logic        hsync_in, vsync_in, de_in;
    logic        pix_valid, line_done, frame_done, err_h, err_v, locked;
    logic [23:0] pix_data;
    logic [10:0] pix_x, pix_y;
    logic [31:0] frame_sum;
    logic [11:0] h_total;

    lcd_rx_monitor #(
        .H_ACTIVE(C_H), .V_ACTIVE(C_V), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(C_LOCK)
    ) dut (
        .clk_in(clk_in), .sys_rst(sys_rst), .rgb_in(rgb_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .line_done(line_done), .frame_done(frame_done), .frame_sum(frame_sum),
        .h_total(h_total), .err_h(err_h), .err_v(err_v), .locked(locked)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int eh_cnt = 0;
    int ev_cnt = 0;
    logic [31:0] last_fsum = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected outputs one clock after the model consumes a sample (p_*),
    // and what must be visible now (e_*).
    logic        p_pv, p_ld, p_fd, p_eh, p_ev, p_locked, p_hvalid;
    logic [23:0] p_pdata;
    logic [10:0] p_px, p_py;
    logic [31:0] p_fsum;
    logic [11:0] p_htot;
    logic        e_pv, e_ld, e_fd, e_eh, e_ev, e_locked, e_hvalid;
    logic [23:0] e_pdata;
    logic [10:0] e_px, e_py;
    logic [31:0] e_fsum;
    logic [11:0] e_htot;

    bit          m_synced, m_locked, m_bad, m_drop, m_have_hs;
    bit          m_pacc, m_pvs, m_phs;
    int          m_streak, m_x, m_y, m_idx, m_last_hs;
    logic [31:0] m_sum;

    task automatic model_reset();
        {p_pv, p_ld, p_fd, p_eh, p_ev, p_locked, p_hvalid} = '0;
        {e_pv, e_ld, e_fd, e_eh, e_ev, e_locked, e_hvalid} = '0;
        p_pdata = '0; p_px = '0; p_py = '0; p_fsum = '0; p_htot = '0;
        e_pdata = '0; e_px = '0; e_py = '0; e_fsum = '0; e_htot = '0;
        m_synced = 0; m_locked = 0; m_bad = 0; m_drop = 0; m_have_hs = 0;
        m_pacc = 0; m_pvs = 0; m_phs = 0;
        m_streak = 0; m_x = 0; m_y = 0; m_idx = 0; m_last_hs = 0; m_sum = '0;
    endtask

    task automatic model_step(input bit acc, input bit vs, input bit hs, input logic [23:0] rgb);
        bit trail, vlead, hlead;
        int lines;
        if (m_drop && m_locked) begin
            m_locked = 0;
            m_streak = 0;
        end
        p_pv = 0; p_ld = 0; p_fd = 0; p_eh = 0; p_ev = 0;
        trail = m_pacc && !acc;
        vlead = vs && !m_pvs;
        hlead = hs && !m_phs;
        lines = m_y;
        if (trail) begin
            p_ld  = 1;
            lines = (m_y + 1 > 2047) ? 2047 : m_y + 1;
            if (m_synced && m_x != C_H) begin
                p_eh  = 1;
                m_bad = 1;
            end
            m_x = 0;
            m_y = lines;
        end
        if (acc) begin
            p_pv = 1; p_pdata = rgb; p_px = 11'(m_x); p_py = 11'(m_y);
            if (m_x < 2047) m_x++;
            m_sum = m_sum + {8'd0, rgb};
        end
        if (vlead) begin
            if (m_synced) begin
                p_fd   = 1;
                p_fsum = m_sum;
                p_ev   = (lines != C_V);
                if (!m_bad && !p_ev) begin
                    m_streak++;
                    if (m_streak >= C_LOCK) m_locked = 1;
                end else begin
                    m_streak = 0;
                    m_locked = 0;
                end
            end
            m_synced = 1; m_x = 0; m_y = 0; m_sum = '0; m_bad = 0;
        end
        if (hlead) begin
            if (m_have_hs) begin
                p_htot   = 12'((m_idx - m_last_hs > 4095) ? 4095 : m_idx - m_last_hs);
                p_hvalid = 1;
            end
            m_have_hs = 1;
            m_last_hs = m_idx;
        end
        m_idx++;
        p_locked = m_locked;
        m_drop   = p_eh || p_ev;
        m_pacc = acc; m_pvs = vs; m_phs = hs;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or posedge sys_rst);
            if (sys_rst) begin
                model_reset();
            end else begin
                e_pv = p_pv; e_ld = p_ld; e_fd = p_fd; e_eh = p_eh; e_ev = p_ev;
                e_locked = p_locked; e_hvalid = p_hvalid; e_pdata = p_pdata;
                e_px = p_px; e_py = p_py; e_fsum = p_fsum; e_htot = p_htot;
                model_step(de_in && vsync_in, !vsync_in, !hsync_in, rgb_in);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk_in);
            #2;
            chk("pix_valid", pix_valid, e_pv);
            chk("pix_data", pix_data, e_pdata);
            if (e_pv) begin
                chk("pix_x", pix_x, e_px);
                chk("pix_y", pix_y, e_py);
            end
            chk("line_done", line_done, e_ld);
            chk("frame_done", frame_done, e_fd);
            chk("frame_sum", frame_sum, e_fsum);
            chk("err_h", err_h, e_eh);
            chk("err_v", err_v, e_ev);
            chk("locked", locked, e_locked);
            if (e_hvalid) chk("h_total", h_total, e_htot);
            if (frame_done) begin
                fd_cnt++;
                last_fsum = frame_sum;
            end
            if (err_h) eh_cnt++;
            if (err_v) ev_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_line(input bit vs, input int len, input int y, input bit rnd,
                              input bit vsde, input int ncyc, input int rst_at);
        for (int c = 0; c < ncyc; c++) begin
            hsync_in = (c < 2) ? 1'b0 : 1'b1;
            vsync_in = vs ? 1'b0 : 1'b1;
            if (c >= 5 && c < 5 + len) begin
                de_in  = 1'b1;
                rgb_in = rnd ? 24'($urandom) : 24'(y * C_H + c - 5);
            end else begin
                de_in  = vsde && (c >= 8) && (c < 10);
                rgb_in = 24'($urandom);
            end
            if (c == rst_at) begin
                sys_rst = 1'b1;
                #1;
                chk("rst_pix_valid", pix_valid, 0);
                chk("rst_pix_data", pix_data, 0);
                chk("rst_pix_x", pix_x, 0);
                chk("rst_frame_sum", frame_sum, 0);
                chk("rst_h_total", h_total, 0);
                chk("rst_locked", locked, 0);
            end else begin
                sys_rst = 1'b0;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic drive_frame(input int nlines, input int short_line, input bit rnd,
                               input bit vsde, input bit tight, input int rst_line);
        int len;
        drive_line(1, 0, 0, 0, vsde, 20, -1);
        drive_line(1, 0, 0, 0, 0, 20, -1);
        drive_line(0, 0, 0, 0, 0, 20, -1);
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? C_H - 1 : C_H;
            drive_line(0, len, l, rnd, 0,
                       (tight && l == nlines - 1) ? 5 + len : 20,
                       (l == rst_line) ? 9 : -1);
        end
        if (!tight) drive_line(0, 0, 0, 0, 0, 20, -1);
    endtask

    initial begin
        int nl, sl;
        sys_rst = 1'b1; rgb_in = '0; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_frame_sum", frame_sum, 0);
        chk("reset_locked", locked, 0);
        chk("reset_h_total", h_total, 0);
        sys_rst = 1'b0;

        repeat (4) drive_frame(4, -1, 0, 0, 0, -1);
        chk("clean_locked", locked, 1);
        chk("clean_fd_cnt", fd_cnt, 3);
        chk("clean_sum", last_fsum, 496);
        chk("h_total_20", h_total, 20);
        chk("clean_errh", eh_cnt, 0);
        chk("clean_errv", ev_cnt, 0);

        drive_frame(4, 2, 0, 0, 0, -1);
        chk("short_errh", eh_cnt, 1);
        chk("short_unlock", locked, 0);

        repeat (2) drive_frame(4, -1, 0, 0, 0, -1);
        drive_frame(5, -1, 0, 0, 0, -1);
        chk("relock", locked, 1);

        drive_frame(4, -1, 0, 1, 0, -1);
        chk("errv_cnt", ev_cnt, 1);
        chk("errv_sum40", last_fsum, 780);
        chk("errv_unlock", locked, 0);
        chk("errv_fd_cnt", fd_cnt, 8);

        drive_frame(4, -1, 0, 0, 0, 1);
        chk("vsde_sum", last_fsum, 496);
        chk("vsde_errv", ev_cnt, 1);
        chk("partial_errh", eh_cnt, 1);
        chk("partial_fd_cnt", fd_cnt, 9);
        drive_frame(4, -1, 0, 0, 0, -1);
        chk("search_no_fd", fd_cnt, 9);
        drive_frame(4, -1, 0, 0, 0, -1);
        chk("first_fd_after_rst", fd_cnt, 10);
        chk("first_sum_after_rst", last_fsum, 496);

        for (int f = 0; f < 10; f++) begin
            nl = $urandom_range(3, 5);
            sl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
            drive_frame(nl, sl, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
        drive_frame(4, -1, 0, 0, 0, -1);
        repeat (5) @(negedge clk_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_rx_monitor.md
Name: lcd_rx_monitor

Overview:
- Receiving end of the parallel RGB LCD interface: samples rgb/hsync/vsync/de as driven by the LCD timing generator.
- Rebuilds the pixel coordinates and pixel stream, and checks active-region geometry per line and per frame.
- Accumulates a per-frame pixel checksum and reports link lock.
- Used in loopback and bring-up builds to verify the calculator display path without a panel.

Parameters:
- H_ACTIVE, 800, expected de-high cycles per active line (1..2047)
- V_ACTIVE, 480, expected active lines per frame (1..2047)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low; 0 = asserted high
- LOCK_FRAMES, 2, consecutive error-free frames required to assert locked (1..15)

Ports:
- clk_in  in  1  pixel clock, same clock that launches the LCD signals
- sys_rst  in  1  asynchronous active-high reset
- rgb_in  in  24  pixel data {R,G,B}
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- de_in  in  1  data enable, active high
- pix_valid  out  1  pix_data/pix_x/pix_y hold a received active pixel
- pix_data  out  24  received pixel
- pix_x  out  11  column of current pixel, 0-based
- pix_y  out  11  row of current pixel, 0-based
- line_done  out  1  1-cycle pulse at the end of each active line
- frame_done  out  1  1-cycle pulse at each frame boundary after the first
- frame_sum  out  32  checksum of the last complete frame
- h_total  out  12  clocks between the last two hsync leading edges, saturating at 4095
- err_h  out  1  1-cycle pulse: line de length != H_ACTIVE
- err_v  out  1  1-cycle pulse: frame active line count != V_ACTIVE
- locked  out  1  LOCK_FRAMES consecutive clean frames seen

Behaviour:
- Reset: all outputs and internal state are 0; FSM enters SEARCH.
- Input path: all inputs are registered (stage 1) and registered again (stage 2) for edge detection. The sync level is normalised by SYNC_ACTIVE_LOW.
- Leading edge means a transition to the asserted level. Trailing edge of de means de goes 1 -> 0.
- Pixel path: when stage-1 de=1 and vsync is deasserted, the next cycle drives pix_valid=1, pix_data=rgb, and the current x/y. Latency from input to pix_valid is 2 clocks. pix_valid=0 otherwise; pix_data holds its value.
- de while vsync is asserted is ignored: no pixel is output, nothing is counted or summed.
- x counter: increments per accepted pixel and saturates at 2047. On the de trailing edge:
  - line_done pulses.
  - If run length != H_ACTIVE, err_h pulses in the same cycle.
  - x clears and the line counter increments, saturating at 2047.
- pix_y = line counter; cleared on the vsync leading edge.
- h counter: restarts at 1 on each hsync leading edge. Its previous value is latched into h_total, saturating at 4095.
- Checksum: sum of the zero-extended 24-bit rgb over accepted pixels, mod 2^32. Cleared on the vsync leading edge.
- FSM:
  - SEARCH: no checks; err_h and err_v are suppressed; frame_done does not pulse. A vsync leading edge moves to SYNCED and clears the counters and sum.
  - SYNCED / LOCKED, on each vsync leading edge:
    - frame_done pulses; frame_sum is loaded with the accumulated sum.
    - err_v pulses if line count != V_ACTIVE.
    - The clean-frame counter increments if the frame had no err_h and no err_v, otherwise it clears.
    - Reaching LOCK_FRAMES moves the FSM to LOCKED with locked=1.
  - Any err_h or err_v while LOCKED: return to SYNCED with locked=0 the next cycle, clean counter=0.
- Simultaneous de trailing edge and vsync leading edge: the line is closed first, so the line count includes it; then the frame is closed in the same cycle.
- Reset mid-frame returns to SEARCH; the partial frame after reset is never checked or summed.

Test Plan:
- Sim with H_ACTIVE=8, V_ACTIVE=4, LOCK_FRAMES=2. Drive 3 clean frames, pixel value = y*8+x -> pix_x 0..7 and pix_y 0..3 match the stimulus with 2-clock latency. frame_sum=496 at each frame_done. locked=1 after the 2nd checked frame. No err pulses.
- Hold hsync period at 20 clocks -> h_total=20 after the second hsync.
- Drop one de cycle on line 2 (7-pixel line) -> err_h pulses at that line's end; locked falls and is regained after 2 further clean frames.
- Send a frame with 5 active lines -> err_v pulses at the next vsync edge; frame_sum includes all 40 pixels.
- Assert sys_rst mid-line during frame 2 -> all outputs 0 immediately. The partial frame raises no errors and no frame_done. The first frame_done comes one frame after the next vsync edge.
- Assert de for 2 cycles during vsync-active -> no pix_valid, sum unchanged, line count unchanged.
